// File: rtl/mux_sweep_sequencer.sv
// Drives the async select/chip-select mux through sel 0..3 and folds each
// sampled result into a rotate-XOR signature.
module mux_sweep_sequencer #(
  parameter int WIDTH = 8,
  parameter int DWELL = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_alpha,
  input  logic [WIDTH-1:0] load_beta,
  input  logic [WIDTH-1:0] load_gamma,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [1:0]       sel,
  output logic             cs,
  output logic [WIDTH-1:0] alpha,
  output logic [WIDTH-1:0] beta,
  output logic [WIDTH-1:0] gamma,
  input  logic [WIDTH-1:0] mux_out,
  output logic             sample_valid,
  output logic [WIDTH-1:0] signature
);

  // state  | meaning
  // IDLE   | operands loadable, waiting for start
  // SWEEP  | cs=1, stepping sel 0..3, DWELL cycles per step
  // FINISH | one-cycle done pulse, then back to IDLE
  typedef enum logic [1:0] {IDLE, SWEEP, FINISH} state_t;

  localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);
  // With a one-cycle dwell every SWEEP cycle is a sample cycle.
  localparam logic SV_FIRST = (DWELL == 1);

  state_t           state_q, state_d;
  logic [7:0]       dwell_q, dwell_d;
  logic [1:0]       sel_d;
  logic             cs_d, done_d, sv_d;
  logic [WIDTH-1:0] alpha_d, beta_d, gamma_d, sig_d;

  assign load_ready = (state_q == IDLE);
  assign busy       = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    dwell_d = dwell_q;
    sel_d   = sel;
    cs_d    = cs;
    done_d  = 1'b0;
    sv_d    = 1'b0;
    alpha_d = alpha;
    beta_d  = beta;
    gamma_d = gamma;
    sig_d   = signature;
    case (state_q)
      IDLE: begin
        cs_d  = 1'b0;
        sel_d = 2'd0;
        if (load_valid) begin
          alpha_d = load_alpha;
          beta_d  = load_beta;
          gamma_d = load_gamma;
        end
        if (start) begin
          sig_d   = '0;
          dwell_d = 8'd0;
          cs_d    = 1'b1;
          sv_d    = SV_FIRST;
          state_d = SWEEP;
        end
      end
      SWEEP: begin
        // sample_valid is registered one cycle ahead, so it marks the sample edge.
        if (sample_valid) begin
          sig_d   = {signature[WIDTH-2:0], signature[WIDTH-1]} ^ mux_out;
          dwell_d = 8'd0;
          if (sel == 2'd3) begin
            state_d = FINISH;
            cs_d    = 1'b0;
            sel_d   = 2'd0;
            done_d  = 1'b1;
          end else begin
            sel_d = sel + 2'd1;
            sv_d  = SV_FIRST;
          end
        end else begin
          dwell_d = dwell_q + 8'd1;
          sv_d    = ((dwell_q + 8'd1) == DWELL_LAST);
        end
      end
      FINISH: begin
        state_d = IDLE;
        cs_d    = 1'b0;
        sel_d   = 2'd0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      dwell_q      <= 8'd0;
      sel          <= 2'd0;
      cs           <= 1'b0;
      done         <= 1'b0;
      sample_valid <= 1'b0;
      alpha        <= '0;
      beta         <= '0;
      gamma        <= '0;
      signature    <= '0;
    end else begin
      state_q      <= state_d;
      dwell_q      <= dwell_d;
      sel          <= sel_d;
      cs           <= cs_d;
      done         <= done_d;
      sample_valid <= sv_d;
      alpha        <= alpha_d;
      beta         <= beta_d;
      gamma        <= gamma_d;
      signature    <= sig_d;
    end
  end

endmodule

// File: tb/tb_mux_sweep_sequencer.sv
// Directed bench for mux_sweep_sequencer: one instance with DWELL=1 and one
// with DWELL=3, each closed around a behavioural model of the mux.
module tb_mux_sweep_sequencer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  function automatic logic [7:0] mux_ref(input logic c, input logic [1:0] s,
                                         input logic [7:0] a, input logic [7:0] b,
                                         input logic [7:0] g);
    if (!c) return 8'h00;
    case (s)
      2'd0:    return a;
      2'd1:    return b;
      2'd2:    return g;
      default: return a & (b | g);
    endcase
  endfunction

  // DWELL=1 instance
  logic       lv1, lr1, st1, busy1, done1, cs1, sv1;
  logic [7:0] la1, lb1, lg1, a1, b1, g1, mo1, sig1;
  logic [1:0] sel1;
  assign mo1 = mux_ref(cs1, sel1, a1, b1, g1);

  mux_sweep_sequencer #(.WIDTH(8), .DWELL(1)) dut1 (
    .clk(clk), .reset(reset), .load_valid(lv1), .load_ready(lr1),
    .load_alpha(la1), .load_beta(lb1), .load_gamma(lg1), .start(st1),
    .busy(busy1), .done(done1), .sel(sel1), .cs(cs1), .alpha(a1), .beta(b1),
    .gamma(g1), .mux_out(mo1), .sample_valid(sv1), .signature(sig1));

  // DWELL=3 instance
  logic       lv3, lr3, st3, busy3, done3, cs3, sv3;
  logic [7:0] la3, lb3, lg3, a3, b3, g3, mo3, sig3;
  logic [1:0] sel3;
  assign mo3 = mux_ref(cs3, sel3, a3, b3, g3);

  mux_sweep_sequencer #(.WIDTH(8), .DWELL(3)) dut3 (
    .clk(clk), .reset(reset), .load_valid(lv3), .load_ready(lr3),
    .load_alpha(la3), .load_beta(lb3), .load_gamma(lg3), .start(st3),
    .busy(busy3), .done(done3), .sel(sel3), .cs(cs3), .alpha(a3), .beta(b3),
    .gamma(g3), .mux_out(mo3), .sample_valid(sv3), .signature(sig3));

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] exp_sig1 [4];
  logic [7:0] exp_mux5 [4];
  logic [7:0] exp_sig5 [4];

  initial begin
    exp_sig1 = '{8'h0A, 8'h00, 8'h1E, 8'h36};
    exp_mux5 = '{8'hF0, 8'h0F, 8'h33, 8'h30};
    exp_sig5 = '{8'hF0, 8'hEE, 8'hEE, 8'hED};
    reset = 1'b1;
    lv1 = 0; st1 = 0; la1 = 0; lb1 = 0; lg1 = 0;
    lv3 = 0; st3 = 0; la3 = 0; lb3 = 0; lg3 = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // reset state
    chk("rst_load_ready", lr1, 1);
    chk("rst_busy", busy1, 0);
    chk("rst_cs_sel", {cs1, sel1}, 0);
    chk("rst_sig", sig1, 0);
    chk("rst_done_sv", {done1, sv1}, 0);

    // basic sweep, DWELL=1
    lv1 = 1; la1 = 8'h0A; lb1 = 8'h14; lg1 = 8'h1E;
    step();
    lv1 = 0;
    chk("load_ops", {a1, b1}, 16'h0A14);
    chk("load_gamma", g1, 8'h1E);
    st1 = 1;
    step();
    st1 = 0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("s2_sel%0d", i), {cs1, sel1}, {13'd0, 1'b1, 2'(i)});
      chk($sformatf("s2_sv%0d", i), sv1, 1);
      chk($sformatf("s2_ready%0d", i), lr1, 0);
      step();
      chk($sformatf("s2_sig%0d", i), sig1, exp_sig1[i]);
    end
    chk("s2_done", {done1, busy1, cs1, sv1}, 4'b1100);
    step();
    chk("s2_after_done", {done1, busy1, lr1}, 3'b001);
    chk("s2_sig_hold", sig1, 8'h36);

    // DWELL=3 sweep
    lv3 = 1; la3 = 8'h0A; lb3 = 8'h14; lg3 = 8'h1E; st3 = 1;
    step();
    lv3 = 0; st3 = 0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 3; j++) begin
        chk($sformatf("s3_sel%0d_%0d", i, j), {cs3, sel3}, {13'd0, 1'b1, 2'(i)});
        chk($sformatf("s3_sv%0d_%0d", i, j), sv3, (j == 2) ? 1 : 0);
        chk($sformatf("s3_done%0d_%0d", i, j), done3, 0);
        step();
      end
    end
    chk("s3_done", {done3, busy3, cs3}, 3'b110);
    chk("s3_sig", sig3, 8'h36);
    step();
    chk("s3_idle", {done3, busy3}, 0);

    // start held high, load attempted while busy
    st1 = 1;
    step();
    lv1 = 1; la1 = 8'hFF; lb1 = 8'hFF; lg1 = 8'hFF;
    chk("s4_sweep", {busy1, cs1, sel1}, 4'b1100);
    repeat (3) step();
    chk("s4_sel3", sel1, 3);
    step();
    chk("s4_done", {done1, busy1}, 2'b11);
    chk("s4_sig", sig1, 8'h36);
    step();
    chk("s4_idle", {busy1, lr1, done1}, 3'b010);
    chk("s4_ops_kept", {a1, b1}, 16'h0A14);
    lv1 = 0;
    step();
    chk("s4_restart", {busy1, cs1, sel1}, 4'b1100);
    chk("s4_ops_after", g1, 8'h1E);
    st1 = 0;
    repeat (4) step();
    chk("s4_done2", {done1, sig1}, {7'd0, 1'b1, 8'h36});
    step();

    // simultaneous load and start
    lv1 = 1; la1 = 8'hF0; lb1 = 8'h0F; lg1 = 8'h33; st1 = 1;
    step();
    lv1 = 0; st1 = 0;
    chk("s5_alpha", a1, 8'hF0);
    chk("s5_sig_clear", sig1, 0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("s5_mux%0d", i), mo1, exp_mux5[i]);
      step();
      chk($sformatf("s5_sig%0d", i), sig1, exp_sig5[i]);
    end
    chk("s5_done", done1, 1);
    step();

    // all-zero sweep
    lv1 = 1; la1 = 0; lb1 = 0; lg1 = 0; st1 = 1;
    step();
    lv1 = 0; st1 = 0;
    repeat (4) step();
    chk("s6_done", {done1, sig1}, {7'd0, 1'b1, 8'h00});
    repeat (4) step();
    chk("s6_hold", {busy1, sig1}, 0);

    // asynchronous reset mid-sweep at sel=2
    lv1 = 1; la1 = 8'h0A; lb1 = 8'h14; lg1 = 8'h1E; st1 = 1;
    step();
    lv1 = 0; st1 = 0;
    repeat (2) step();
    chk("s1_pre_sel", {cs1, sel1}, 3'b110);
    #2 reset = 1'b1;
    #1;
    chk("s1_cs_sel", {cs1, sel1}, 0);
    chk("s1_sig", sig1, 0);
    chk("s1_ops", {a1, b1}, 0);
    chk("s1_gamma_ready", {g1, lr1}, 9'b1);
    chk("s1_busy_done", {busy1, done1}, 0);
    step();
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("s1_nodone%0d", k), {done1, busy1, sv1}, 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
